// File: rtl/reg_file_cc.sv
// LC-3 register file: 8 GPRs with two combinational read ports, plus the
// NZP condition-code latch and the branch-enable latch that feeds the control FSM.

module reg_file_cc_gpr #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     q_q <= '0;
    else if (we_i) q_q <= d_i;
  end

  assign q_o = q_q;

endmodule

module reg_file_cc #(
  parameter int         WIDTH    = 16,
  parameter int         NREGS    = 8,
  parameter logic [2:0] CC_RESET = 3'b010
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] bus_i,
  input  logic             ld_reg_i,
  input  logic [2:0]       dr_i,
  input  logic [2:0]       sr1_i,
  input  logic [2:0]       sr2_i,
  output logic [WIDTH-1:0] sr1_out_o,
  output logic [WIDTH-1:0] sr2_out_o,
  input  logic             ld_cc_i,
  input  logic             ld_ben_i,
  input  logic [2:0]       ir_nzp_i,
  output logic             n_o,
  output logic             z_o,
  output logic             p_o,
  output logic             ben_o
);

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  logic [NREGS-1:0][WIDTH-1:0] gpr_q;
  logic [NREGS-1:0]            we;

  // ld_reg_i gates the decode, so an unknown DR with no load cannot enable any write
  for (genvar g = 0; g < NREGS; g++) begin : g_gpr
    assign we[g] = ld_reg_i & (dr_i == 3'(g));

    reg_file_cc_gpr #(.WIDTH(WIDTH)) u_gpr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .we_i  (we[g]),
      .d_i   (bus_i),
      .q_o   (gpr_q[g])
    );
  end

  assign sr1_out_o = gpr_q[sr1_i];
  assign sr2_out_o = gpr_q[sr2_i];

  nzp_t cc_q, cc_d;
  logic ben_q, ben_d;

  always_comb begin
    cc_d = cc_q;
    if (ld_cc_i) begin
      cc_d.n = bus_i[WIDTH-1];
      cc_d.z = (bus_i == '0);
      cc_d.p = ~bus_i[WIDTH-1] & (bus_i != '0);
    end
  end

  // BEN reads the flags as they stood before this edge, even when LD_CC fires too
  always_comb begin
    ben_d = ben_q;
    if (ld_ben_i) ben_d = |(ir_nzp_i & cc_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cc_q  <= nzp_t'(CC_RESET);
      ben_q <= 1'b0;
    end else begin
      cc_q  <= cc_d;
      ben_q <= ben_d;
    end
  end

  assign n_o   = cc_q.n;
  assign z_o   = cc_q.z;
  assign p_o   = cc_q.p;
  assign ben_o = ben_q;

endmodule

// File: tb/tb_reg_file_cc.sv
// Randomized and directed bench for reg_file_cc against an array/flag reference model.

module tb_reg_file_cc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] bus_i;
  logic        ld_reg_i;
  logic [2:0]  dr_i, sr1_i, sr2_i;
  logic [15:0] sr1_out_o, sr2_out_o;
  logic        ld_cc_i, ld_ben_i;
  logic [2:0]  ir_nzp_i;
  logic        n_o, z_o, p_o, ben_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // reference model
  logic [15:0] m_reg [8];
  logic [2:0]  m_nzp;
  logic        m_ben;

  reg_file_cc dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .bus_i     (bus_i),
    .ld_reg_i  (ld_reg_i),
    .dr_i      (dr_i),
    .sr1_i     (sr1_i),
    .sr2_i     (sr2_i),
    .sr1_out_o (sr1_out_o),
    .sr2_out_o (sr2_out_o),
    .ld_cc_i   (ld_cc_i),
    .ld_ben_i  (ld_ben_i),
    .ir_nzp_i  (ir_nzp_i),
    .n_o       (n_o),
    .z_o       (z_o),
    .p_o       (p_o),
    .ben_o     (ben_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 16'h0;
    m_nzp = 3'b010;
    m_ben = 1'b0;
  endtask

  // Drive one cycle's controls, advance model by one edge, return 1ns after the edge.
  task automatic cycle(input logic ld_reg, input logic [2:0] dr, input logic [15:0] bus,
                       input logic ld_cc, input logic ld_ben, input logic [2:0] ir);
    int sv;
    ld_reg_i = ld_reg; dr_i = dr; bus_i = bus;
    ld_cc_i = ld_cc; ld_ben_i = ld_ben; ir_nzp_i = ir;
    @(posedge clk_i);
    if (ld_ben) m_ben = ((ir & m_nzp) != 3'b000);
    if (ld_reg) m_reg[dr] = bus;
    if (ld_cc) begin
      sv = int'($signed(bus));
      m_nzp = (sv < 0) ? 3'b100 : (sv == 0) ? 3'b010 : 3'b001;
    end
    #1;
    ld_reg_i = 1'b0; ld_cc_i = 1'b0; ld_ben_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ld_reg_i = 0; ld_cc_i = 0; ld_ben_i = 0; dr_i = 0; bus_i = 0; ir_nzp_i = 0;
    sr1_i = 0; sr2_i = 0;
    model_reset();
    #12;
    for (int i = 0; i < 8; i++) begin
      sr1_i = 3'(i); sr2_i = 3'(7 - i); #1;
      chk_cnt++;
      if (sr1_out_o !== 16'h0 || sr2_out_o !== 16'h0)
        $display("FAIL reset_read idx=%0d got %h/%h want 0000/0000", i, sr1_out_o, sr2_out_o);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({n_o, z_o, p_o, ben_o} !== 4'b0100)
      $display("FAIL reset_flags got nzp,ben=%b want 0100", {n_o, z_o, p_o, ben_o});
    else pass_cnt++;
    // loads held high while in reset must be ignored
    ld_reg_i = 1; dr_i = 3; bus_i = 16'h8001; ld_cc_i = 1; ld_ben_i = 1; ir_nzp_i = 3'b111;
    @(posedge clk_i); #1;
    sr1_i = 3;
    #1;
    chk_cnt++;
    if (sr1_out_o !== 16'h0 || {n_o, z_o, p_o, ben_o} !== 4'b0100)
      $display("FAIL reset_holds got r3=%h nzp,ben=%b want 0000/0100", sr1_out_o, {n_o, z_o, p_o, ben_o});
    else pass_cnt++;
    ld_reg_i = 0; ld_cc_i = 0; ld_ben_i = 0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_write_read();
    cycle(1, 3'd3, 16'h1234, 0, 0, 3'b000);
    for (int i = 0; i < 8; i++) begin
      sr1_i = 3'(i); #1;
      chk_cnt++;
      if (sr1_out_o !== m_reg[i])
        $display("FAIL write_read R%0d got %h want %h", i, sr1_out_o, m_reg[i]);
      else pass_cnt++;
    end
    sr1_i = 3; sr2_i = 3; #1;
    chk_cnt++;
    if (sr1_out_o !== 16'h1234 || sr2_out_o !== 16'h1234)
      $display("FAIL same_src got %h/%h want 1234/1234", sr1_out_o, sr2_out_o);
    else pass_cnt++;
  endtask

  task automatic test_cc();
    logic [15:0] vals [3];
    logic [2:0]  want [3];
    vals[0] = 16'h8000; want[0] = 3'b100;
    vals[1] = 16'h0000; want[1] = 3'b010;
    vals[2] = 16'h7FFF; want[2] = 3'b001;
    for (int i = 0; i < 3; i++) begin
      cycle(0, 3'd0, vals[i], 1, 0, 3'b000);
      chk_cnt++;
      if ({n_o, z_o, p_o} !== want[i] || m_nzp !== want[i])
        $display("FAIL cc_%h got nzp=%b want %b", vals[i], {n_o, z_o, p_o}, want[i]);
      else pass_cnt++;
    end
    cycle(0, 3'd0, 16'hFFFF, 0, 0, 3'b000);
    chk_cnt++;
    if ({n_o, z_o, p_o} !== 3'b001)
      $display("FAIL cc_hold got nzp=%b want 001", {n_o, z_o, p_o});
    else pass_cnt++;
  endtask

  task automatic test_ben_order();
    cycle(0, 3'd0, 16'h0000, 1, 0, 3'b000);
    cycle(0, 3'd0, 16'h0005, 1, 1, 3'b010);
    chk_cnt++;
    if (ben_o !== 1'b1 || {n_o, z_o, p_o} !== 3'b001)
      $display("FAIL ben_old_cc got ben=%b nzp=%b want 1/001", ben_o, {n_o, z_o, p_o});
    else pass_cnt++;
    cycle(0, 3'd0, 16'h0000, 0, 1, 3'b010);
    chk_cnt++;
    if (ben_o !== 1'b0) $display("FAIL ben_next got %b want 0", ben_o);
    else pass_cnt++;
    cycle(0, 3'd0, 16'h0000, 0, 1, 3'b111);
    chk_cnt++;
    if (ben_o !== 1'b1) $display("FAIL ben_mask111 got %b want 1", ben_o);
    else pass_cnt++;
    cycle(0, 3'd0, 16'h0000, 0, 0, 3'b000);
    chk_cnt++;
    if (ben_o !== 1'b1) $display("FAIL ben_hold got %b want 1", ben_o);
    else pass_cnt++;
    cycle(0, 3'd0, 16'h0000, 0, 1, 3'b000);
    chk_cnt++;
    if (ben_o !== 1'b0) $display("FAIL ben_mask000 got %b want 0", ben_o);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    cycle(1, 3'd7, 16'hFFFE, 1, 0, 3'b000);
    sr2_i = 7; #1;
    chk_cnt++;
    if (sr2_out_o !== 16'hFFFE || {n_o, z_o, p_o} !== 3'b100)
      $display("FAIL simul got r7=%h nzp=%b want fffe/100", sr2_out_o, {n_o, z_o, p_o});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 8; i++) cycle(1, 3'(i), 16'hA5A5 + 16'(i), 1, 1, 3'b111);
    // arm a load that the reset must discard
    ld_reg_i = 1; dr_i = 2; bus_i = 16'h5555; ld_cc_i = 1; ld_ben_i = 1; ir_nzp_i = 3'b111;
    #2 rst_i = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 8; i++) begin
      sr1_i = 3'(i); sr2_i = 3'(i); #0.1;
      chk_cnt++;
      if (sr1_out_o !== 16'h0 || sr2_out_o !== 16'h0)
        $display("FAIL midrst_R%0d got %h/%h want 0000/0000", i, sr1_out_o, sr2_out_o);
      else pass_cnt++;
    end
    chk_cnt++;
    if ({n_o, z_o, p_o, ben_o} !== 4'b0100)
      $display("FAIL midrst_flags got %b want 0100", {n_o, z_o, p_o, ben_o});
    else pass_cnt++;
    ld_reg_i = 0; ld_cc_i = 0; ld_ben_i = 0;
    #1 rst_i = 1'b0;
    cycle(1, 3'd5, 16'hBEEF, 0, 0, 3'b000);
    sr1_i = 5; sr2_i = 4; #1;
    chk_cnt++;
    if (sr1_out_o !== 16'hBEEF || sr2_out_o !== 16'h0)
      $display("FAIL post_rst_write got %h/%h want beef/0000", sr1_out_o, sr2_out_o);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [15:0] b;
    for (int c = 0; c < 300; c++) begin
      case ($urandom_range(0, 3))
        0: b = 16'h0000;
        1: b = 16'h8000;
        2: b = 16'h7FFF;
        default: b = 16'($urandom);
      endcase
      cycle(1'($urandom), 3'($urandom), b, 1'($urandom), 1'($urandom), 3'($urandom));
      sr1_i = 3'($urandom); sr2_i = 3'($urandom); #1;
      chk_cnt++;
      if (sr1_out_o !== m_reg[sr1_i] || sr2_out_o !== m_reg[sr2_i] ||
          {n_o, z_o, p_o} !== m_nzp || ben_o !== m_ben)
        $display("FAIL random c=%0d got %h/%h nzp=%b ben=%b want %h/%h nzp=%b ben=%b", c,
                 sr1_out_o, sr2_out_o, {n_o, z_o, p_o}, ben_o,
                 m_reg[sr1_i], m_reg[sr2_i], m_nzp, m_ben);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_cc();
    test_ben_order();
    test_simultaneous();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
